// File: rtl/ooo_pkg.sv
// ooo_pkg -- constants and types shared by the out-of-order issue path
// (reservation stations and functional units).
//   TAG_W / DATA_W : ROB tag and data widths
//   opcode_e       : ALU opcode encodings (values 8..255 are illegal)
//   FLAG_*         : bit positions within the 8-bit result-flag field
//   result_t       : one completed result as broadcast on the CDB
package ooo_pkg;

   localparam int TAG_W  = 4;
   localparam int DATA_W = 8;

   typedef enum logic [7:0] {
      OP_ADD = 8'd0,
      OP_ADC = 8'd1,
      OP_SUB = 8'd2,
      OP_AND = 8'd3,
      OP_OR  = 8'd4,
      OP_XOR = 8'd5,
      OP_SHL = 8'd6,
      OP_SHR = 8'd7
   } opcode_e;

   localparam int FLAG_CARRY   = 0;
   localparam int FLAG_ZERO    = 1;
   localparam int FLAG_NEG     = 2;
   localparam int FLAG_ILLEGAL = 7;

   typedef struct packed {
      logic [TAG_W-1:0]  robid;
      logic [DATA_W-1:0] value;
      logic [DATA_W-1:0] wbs;
      logic [DATA_W-1:0] flags;
   } result_t;

endpackage

// File: rtl/alu_core.sv
// alu_core -- purely combinational opcode decode, datapath and flag generation.
//   opcode   : operation select (ooo_pkg::opcode_e; other values are illegal)
//   a, b     : source operands
//   carry_in : carry input used only by ADC
//   result   : 8-bit result (modulo 256)
//   flags    : carry / zero / negative / illegal, bits 6:3 always 0
import ooo_pkg::*;

module alu_core (
   input  logic [DATA_W-1:0] opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              carry_in,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] flags
);

   logic [DATA_W:0] sum;
   logic            carry;
   logic            illegal;

   // Operation select; unknown opcodes pass A through and raise the illegal flag
   always_comb begin
      sum     = 9'd0;
      carry   = 1'b0;
      illegal = 1'b0;
      result  = 8'd0;
      case (opcode)
         OP_ADD: begin
            sum    = {1'b0, a} + {1'b0, b};
            result = sum[7:0];
            carry  = sum[8];
         end
         OP_ADC: begin
            sum    = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
            result = sum[7:0];
            carry  = sum[8];
         end
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);   // borrow
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL:  result = a << b[2:0];
         OP_SHR:  result = a >> b[2:0];
         default: begin
            result  = a;
            illegal = 1'b1;
         end
      endcase
   end

   // Flag assembly from the selected result
   always_comb begin
      flags               = 8'd0;
      flags[FLAG_CARRY]   = carry;
      flags[FLAG_ZERO]    = (result == 8'd0);
      flags[FLAG_NEG]     = result[7];
      flags[FLAG_ILLEGAL] = illegal;
   end

endmodule

// File: rtl/alu_fu.sv
// alu_fu -- ALU functional unit: accepts one issue per cycle from the RS
// chain, computes it in alu_core, and queues results in a DEPTH-entry FIFO
// that is drained in issue order onto the common data bus (CDB).
//   clk, rst        : clock, synchronous active-high reset
//   futransmit      : RS presents a valid issue
//   operandin       : opcode
//   wbsin, flagin   : writeback selector, issue flags (bit0 = carry-in)
//   robidin         : destination ROB tag
//   depvalsin       : operands, A = [0], B = [1]
//   fuclaimed       : FIFO full, issue not accepted
//   cdbreq          : head result available
//   cdbgrant        : arbiter takes the head this cycle
//   cdbrobid/cdbval/cdbwbs/cdbflag : head entry, all zero when empty
import ooo_pkg::*;

module alu_fu #(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   futransmit,
   input  logic [DATA_W-1:0]      operandin,
   input  logic [DATA_W-1:0]      wbsin,
   input  logic [DATA_W-1:0]      flagin,
   input  logic [TAG_W-1:0]       robidin,
   input  logic [1:0][DATA_W-1:0] depvalsin,
   output logic                   fuclaimed,
   output logic                   cdbreq,
   input  logic                   cdbgrant,
   output logic [TAG_W-1:0]       cdbrobid,
   output logic [DATA_W-1:0]      cdbval,
   output logic [DATA_W-1:0]      cdbwbs,
   output logic [DATA_W-1:0]      cdbflag
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   result_t            mem [DEPTH];
   result_t            head;
   result_t            head_next;
   result_t            new_entry;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_next, rd_next;
   logic [CNT_W-1:0]   count, count_next;
   logic               push, pop;
   logic [DATA_W-1:0]  alu_result, alu_flags;
   logic               unused_flagin;

   assign unused_flagin = ^flagin[7:1];

   alu_core u_core (
      .opcode   (operandin),
      .a        (depvalsin[0]),
      .b        (depvalsin[1]),
      .carry_in (flagin[0]),
      .result   (alu_result),
      .flags    (alu_flags)
   );

   assign new_entry = '{robid: robidin, value: alu_result, wbs: wbsin, flags: alu_flags};

   // fuclaimed and cdbreq are registered, so accept/pop never depend
   // combinationally on this cycle's futransmit or cdbgrant.
   assign push = futransmit & ~fuclaimed;
   assign pop  = cdbgrant & cdbreq;

   // Next FIFO state and the entry that will sit at the head next cycle
   always_comb begin
      count_next = count;
      wr_next    = wr_ptr;
      rd_next    = rd_ptr;
      head_next  = '0;
      if (push && !pop) begin
         count_next = count + CNT_W'(1);
      end else if (!push && pop) begin
         count_next = count - CNT_W'(1);
      end else begin
         count_next = count;
      end
      if (push) begin
         wr_next = wr_ptr + PTR_W'(1);
      end else begin
         wr_next = wr_ptr;
      end
      if (pop) begin
         rd_next = rd_ptr + PTR_W'(1);
      end else begin
         rd_next = rd_ptr;
      end
      // The slot being written this cycle becomes head when the FIFO
      // was empty, or held one entry that is popped at the same time.
      if (count_next == CNT_W'(0)) begin
         head_next = '0;
      end else if (push && (rd_next == wr_ptr)) begin
         head_next = new_entry;
      end else begin
         head_next = mem[rd_next];
      end
   end

   // Pointer, count and registered CDB/handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fuclaimed <= 1'b0;
         cdbreq    <= 1'b0;
         head      <= '0;
      end else begin
         count     <= count_next;
         wr_ptr    <= wr_next;
         rd_ptr    <= rd_next;
         fuclaimed <= (count_next == CNT_W'(DEPTH));
         cdbreq    <= (count_next != CNT_W'(0));
         head      <= head_next;
      end
   end

   // Result storage, no reset needed
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= new_entry;
      end
   end

   assign cdbrobid = head.robid;
   assign cdbval   = head.value;
   assign cdbwbs   = head.wbs;
   assign cdbflag  = head.flags;

endmodule

// File: tb/tb_alu_fu.sv
// tb_alu_fu -- self-checking bench for alu_fu (DEPTH = 2). A scoreboard
// queue holds expected CDB entries pushed on accepted issues and popped on
// grants; CDB outputs are checked at every falling edge.
module tb_alu_fu;

   logic            clk = 1'b0;
   logic            rst;
   logic            futransmit;
   logic [7:0]      operandin, wbsin, flagin;
   logic [3:0]      robidin;
   logic [1:0][7:0] depvalsin;
   logic            fuclaimed, cdbreq, cdbgrant;
   logic [3:0]      cdbrobid;
   logic [7:0]      cdbval, cdbwbs, cdbflag;

   always #5 clk = ~clk;

   alu_fu #(.DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .futransmit (futransmit),
      .operandin  (operandin),
      .wbsin      (wbsin),
      .flagin     (flagin),
      .robidin    (robidin),
      .depvalsin  (depvalsin),
      .fuclaimed  (fuclaimed),
      .cdbreq     (cdbreq),
      .cdbgrant   (cdbgrant),
      .cdbrobid   (cdbrobid),
      .cdbval     (cdbval),
      .cdbwbs     (cdbwbs),
      .cdbflag    (cdbflag)
   );

   typedef struct {
      logic [3:0] robid;
      logic [7:0] val;
      logic [7:0] wbs;
      logic [7:0] flag;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference ALU behaviour
   function automatic exp_t ref_alu(input logic [7:0] op, input logic [7:0] a,
                                    input logic [7:0] b, input logic cin,
                                    input logic [3:0] robid, input logic [7:0] wbs);
      exp_t e;
      int   full;
      logic c;
      logic ill;
      logic [7:0] r;
      c = 1'b0; ill = 1'b0; r = 8'h00;
      if (op == 8'd0)      begin full = int'(a) + int'(b);          r = full[7:0]; c = full[8]; end
      else if (op == 8'd1) begin full = int'(a) + int'(b) + int'(cin); r = full[7:0]; c = full[8]; end
      else if (op == 8'd2) begin r = a - b; c = (int'(a) < int'(b)); end
      else if (op == 8'd3) r = a & b;
      else if (op == 8'd4) r = a | b;
      else if (op == 8'd5) r = a ^ b;
      else if (op == 8'd6) r = a << b[2:0];
      else if (op == 8'd7) r = a >> b[2:0];
      else begin r = a; ill = 1'b1; end
      e.robid = robid;
      e.val   = r;
      e.wbs   = wbs;
      e.flag  = {ill, 4'b0000, r[7], (r == 8'h00), c};
      return e;
   endfunction

   task automatic check_outputs();
      check_eq("cdbreq", {31'd0, cdbreq}, {31'd0, (q.size() != 0)});
      check_eq("fuclaimed", {31'd0, fuclaimed}, {31'd0, (q.size() == 2)});
      if (q.size() != 0) begin
         check_eq("cdbrobid", {28'd0, cdbrobid}, {28'd0, q[0].robid});
         check_eq("cdbval",   {24'd0, cdbval},   {24'd0, q[0].val});
         check_eq("cdbwbs",   {24'd0, cdbwbs},   {24'd0, q[0].wbs});
         check_eq("cdbflag",  {24'd0, cdbflag},  {24'd0, q[0].flag});
      end else begin
         check_eq("idle_cdb", {8'd0, cdbrobid, cdbval, cdbwbs, cdbflag}, 32'd0);
      end
   endtask

   // One clock cycle: check outputs, drive inputs, update the scoreboard
   task automatic cycle(input logic r, input logic fut, input logic [7:0] op,
                        input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [3:0] robid, input logic [7:0] wbs, input logic grant);
      logic acc;
      logic pp;
      check_outputs();
      rst = r; futransmit = fut; operandin = op; depvalsin[0] = a; depvalsin[1] = b;
      flagin = {7'd0, cin}; robidin = robid; wbsin = wbs; cdbgrant = grant;
      acc = fut && (q.size() < 2) && !r;
      pp  = grant && (q.size() != 0) && !r;
      if (r) begin
         q.delete();
      end else begin
         if (pp) void'(q.pop_front());
         if (acc) q.push_back(ref_alu(op, a, b, cin, robid, wbs));
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic grant);
      cycle(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 4'd0, 8'd0, grant);
   endtask

   initial begin
      rst = 1'b1; futransmit = 1'b0; operandin = 8'd0; wbsin = 8'd0; flagin = 8'd0;
      robidin = 4'd0; depvalsin = '0; cdbgrant = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state, then ADD 0x7F+0x01 with grant held high
      cycle(1'b0, 1'b1, 8'd0, 8'h7F, 8'h01, 1'b0, 4'd3, 8'h10, 1'b1);
      check_eq("s1_req",   {31'd0, cdbreq}, 32'd1);
      check_eq("s1_robid", {28'd0, cdbrobid}, 32'd3);
      check_eq("s1_val",   {24'd0, cdbval}, 32'h80);
      check_eq("s1_flag",  {24'd0, cdbflag}, 32'h04);
      idle(1'b1);
      check_eq("s1_drain", {31'd0, cdbreq}, 32'd0);

      // SUB equal operands, ADC with carry-in
      cycle(1'b0, 1'b1, 8'd2, 8'h05, 8'h05, 1'b0, 4'd4, 8'h21, 1'b1);
      check_eq("s2_sub_val",  {24'd0, cdbval}, 32'h00);
      check_eq("s2_sub_flag", {24'd0, cdbflag}, 32'h02);
      cycle(1'b0, 1'b1, 8'd1, 8'hFF, 8'h00, 1'b1, 4'd5, 8'h22, 1'b1);
      check_eq("s2_adc_val",  {24'd0, cdbval}, 32'h00);
      check_eq("s2_adc_flag", {24'd0, cdbflag}, 32'h03);
      idle(1'b1);

      // Back-pressure: robids 1,2,3 without grant, 3 refused
      cycle(1'b0, 1'b1, 8'd3, 8'hF0, 8'h3C, 1'b0, 4'd1, 8'h31, 1'b0);
      cycle(1'b0, 1'b1, 8'd4, 8'hF0, 8'h0F, 1'b0, 4'd2, 8'h32, 1'b0);
      check_eq("s3_full", {31'd0, fuclaimed}, 32'd1);
      cycle(1'b0, 1'b1, 8'd5, 8'hAA, 8'h55, 1'b0, 4'd3, 8'h33, 1'b0);
      check_eq("s3_head_still_1", {28'd0, cdbrobid}, 32'd1);
      // Grant while full: fuclaimed stays 1 this cycle, robid 4 refused
      cycle(1'b0, 1'b1, 8'd5, 8'h01, 8'h02, 1'b0, 4'd4, 8'h34, 1'b1);
      check_eq("s3_second", {28'd0, cdbrobid}, 32'd2);
      idle(1'b1);
      check_eq("s3_empty", {31'd0, fuclaimed | cdbreq}, 32'd0);

      // Count 1 with simultaneous issue and grant
      cycle(1'b0, 1'b1, 8'd7, 8'h80, 8'h0F, 1'b0, 4'd6, 8'h41, 1'b0);
      cycle(1'b0, 1'b1, 8'd6, 8'h01, 8'h01, 1'b0, 4'd7, 8'h42, 1'b1);
      check_eq("s4_newhead", {28'd0, cdbrobid}, 32'd7);
      idle(1'b1);

      // Full, then reset together with issue and grant
      cycle(1'b0, 1'b1, 8'd0, 8'h01, 8'h02, 1'b0, 4'd8, 8'h51, 1'b0);
      cycle(1'b0, 1'b1, 8'd0, 8'h03, 8'h04, 1'b0, 4'd9, 8'h52, 1'b0);
      cycle(1'b1, 1'b1, 8'd0, 8'h05, 8'h06, 1'b0, 4'd10, 8'h53, 1'b1);
      check_eq("s5_req",  {31'd0, cdbreq}, 32'd0);
      check_eq("s5_claim", {31'd0, fuclaimed}, 32'd0);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // Illegal opcode and shift count wrap
      cycle(1'b0, 1'b1, 8'h2A, 8'h11, 8'h00, 1'b0, 4'd11, 8'h61, 1'b1);
      check_eq("s6_ill_val",  {24'd0, cdbval}, 32'h11);
      check_eq("s6_ill_flag", {24'd0, cdbflag}, 32'h80);
      cycle(1'b0, 1'b1, 8'd6, 8'h81, 8'h09, 1'b0, 4'd12, 8'h62, 1'b1);
      check_eq("s6_shl_val",  {24'd0, cdbval}, 32'h02);
      check_eq("s6_shl_flag", {24'd0, cdbflag}, 32'h00);
      idle(1'b1);

      // Random traffic against the scoreboard
      for (int i = 0; i < 200; i++) begin
         logic [7:0] rop;
         rop = (($urandom_range(0, 7)) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
         cycle(1'b0, 1'($urandom_range(0, 1)), rop, 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), 8'($urandom),
               1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 4; i++) idle(1'b1);
      check_outputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_fu.md
ALU_FU -- requirements
Module: alu_fu

Interface
REQ-001 Parameter DEPTH, default 2: result-buffer entries, power of two, minimum 2.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 futransmit  input  1  reservation station (RS) chain presents a valid issue this cycle.
REQ-005 operandin  input  8  opcode.
REQ-006 wbsin  input  8  writeback selector; carried unchanged to the result.
REQ-007 flagin  input  8  issue flags; bit0 = carry-in.
REQ-008 robidin  input  4  destination ROB tag.
REQ-009 depvalsin  input  2x8  source operands A=[0], B=[1].
REQ-010 fuclaimed  output  1  unit cannot accept; drives the head of the RS fuclaimed chain.
REQ-011 cdbreq  output  1  result available for broadcast.
REQ-012 cdbgrant  input  1  arbiter accepts the head result this cycle.
REQ-013 cdbrobid  output  4  broadcast tag; feeds RS depins.
REQ-014 cdbval  output  8  broadcast value; feeds RS depinval.
REQ-015 cdbwbs  output  8  broadcast writeback selector.
REQ-016 cdbflag  output  8  result flags.

Function
REQ-017 Issue is accepted in cycle N iff futransmit=1, fuclaimed=0 and rst=0; otherwise the issue inputs are ignored.
REQ-018 fuclaimed shall be 1 exactly when the buffer count equals DEPTH, as a registered-state function with no combinational path from cdbgrant or futransmit.
REQ-019 An accepted issue is computed combinationally in cycle N and written at the end of cycle N; it is visible at the buffer head no earlier than cycle N+1, giving 1-cycle latency when the buffer was empty.
REQ-020 Opcode values: 0 ADD A+B; 1 ADC A+B+carry-in; 2 SUB A-B; 3 AND; 4 OR; 5 XOR; 6 SHL A<<B[2:0]; 7 SHR logical A>>B[2:0].
REQ-021 Opcodes 8-255 shall produce result = A with flag bit7 (illegal) set.
REQ-022 Result flags: bit0 carry (9th sum bit for ADD/ADC; borrow, i.e. A<B, for SUB; 0 otherwise); bit1 zero (result==0); bit2 negative (result[7]); bit7 illegal; bits 6:3 shall be 0.
REQ-023 All arithmetic is 8-bit modulo 256; shift counts use only B[2:0].
REQ-024 The buffer is a FIFO of DEPTH entries {robid, value, wbs, flags} with wrapping read and write pointers and a count of width clog2(DEPTH)+1.
REQ-025 cdbreq = (count != 0); while cdbreq=1, cdbrobid/cdbval/cdbwbs/cdbflag shall show the head entry.
REQ-026 While cdbreq=0, all CDB data outputs shall be 0; tag 0 is reserved as "no broadcast".
REQ-027 cdbgrant=1 with cdbreq=1 pops the head at the end of the cycle.
REQ-028 cdbgrant=1 with cdbreq=0 shall be ignored.
REQ-029 A simultaneous push and pop leaves count unchanged and advances both pointers.
REQ-030 When the buffer is full, cdbgrant=1 frees a slot only from the next cycle: fuclaimed stays 1 during the grant cycle.
REQ-031 The head entry is held stable on the CDB until granted; there is no timeout and no reordering, so results retire in issue order.

Reset
REQ-032 When rst=1 at a clock edge, count and both pointers shall clear to 0, and any issue or grant in the same cycle shall be discarded.
REQ-033 In the cycle after reset: fuclaimed=0, cdbreq=0, all CDB outputs 0.
REQ-034 A reset asserted mid-operation discards all buffered results without broadcasting them.
REQ-035 FIFO storage contents need no reset.

Structure
REQ-036 Opcode encodings, flag bit positions, and tag/data widths (4, 8) shall live in shared package ooo_pkg; the RS uses the same constants.
REQ-037 Opcode decode and flag generation shall be one purely combinational sub-module, alu_core; alu_fu contains the FIFO and the handshake logic.

Verification
REQ-038 Scenario 1: reset, then issue ADD A=0x7F B=0x01 robid=3, cdbgrant tied 1 -> next cycle cdbreq=1, cdbrobid=3, cdbval=0x80, cdbflag=0x04; following cycle cdbreq=0 and outputs 0.
REQ-039 Scenario 2: SUB A=0x05 B=0x05 -> value 0x00, flag 0x02; ADC A=0xFF B=0x00 carry-in=1 -> value 0x00, flag 0x03.
REQ-040 Scenario 3: cdbgrant=0, issue robids 1, 2, 3 on consecutive cycles with DEPTH=2 -> fuclaimed=1 after the second accept and robid 3 is not accepted; grant twice -> broadcasts 1 then 2 in order, then fuclaimed=0.
REQ-041 Scenario 4: count=1 with issue and grant in the same cycle -> count stays 1, the old head is broadcast once, and the new entry is at the head next cycle.
REQ-042 Scenario 5: buffer full, rst=1 together with futransmit and cdbgrant -> next cycle count=0, cdbreq=0, fuclaimed=0, and no stale robid appears on the CDB afterwards.
REQ-043 Scenario 6: opcode 0x2A A=0x11 -> value 0x11, flag 0x80; SHL A=0x81 B=0x09 -> value 0x02, flag 0x00.
